// File: rtl/port_range_cam.sv
// Purpose: L4 port CAM. Extracts a 16-bit port at byte offset PORT_OFFSET+added_offset_in (may straddle
//          two beats), matches it per AXIS ID (exact or inclusive range) and narrows the route mask.
// Latency: 0 cycles. AXI-S is a combinational passthrough and mask/done are valid on the completing beat.
// Backpressure: tready is passed straight through. A beat is consumed only when tvalid & axis_out_tready,
//          so tready low freezes all state.
// Ports: aclk/aresetn; axis_in_* -> axis_out_* passthrough; route_mask_in/parsing_done_in from the previous
//        stage; cur_pos_in is the byte position of beat byte 0; cam_* is the per-ID configuration;
//        route_mask_out/parsing_done_out/short_pkt are the results.
module port_range_cam #(
   parameter int AXIS_BUS_WIDTH    = 64,
   parameter int AXIS_ID_WIDTH     = 4,
   parameter int AXIS_DEST_WIDTH   = 4,
   parameter int MAX_PACKET_LENGTH = 1522,
   parameter int MAX_ADDED_OFFSET  = 64,
   parameter int PORT_OFFSET       = 36,
   localparam int NUM_AXIS_ID         = 2**AXIS_ID_WIDTH,
   localparam int NUM_BUS_BYTES       = AXIS_BUS_WIDTH/8,
   localparam int PACKET_LENGTH_CBITS = $clog2(MAX_PACKET_LENGTH+1),
   localparam int ADDED_CBITS         = $clog2(MAX_ADDED_OFFSET+1)
) (
   input  logic                                 aclk,
   input  logic                                 aresetn,
   input  logic [AXIS_BUS_WIDTH-1:0]            axis_in_tdata,
   input  logic [AXIS_ID_WIDTH-1:0]             axis_in_tid,
   input  logic [AXIS_DEST_WIDTH-1:0]           axis_in_tdest,
   input  logic [NUM_BUS_BYTES-1:0]             axis_in_tkeep,
   input  logic                                 axis_in_tlast,
   input  logic                                 axis_in_tvalid,
   output logic                                 axis_in_tready,
   output logic [AXIS_BUS_WIDTH-1:0]            axis_out_tdata,
   output logic [AXIS_ID_WIDTH-1:0]             axis_out_tid,
   output logic [AXIS_DEST_WIDTH-1:0]           axis_out_tdest,
   output logic [NUM_BUS_BYTES-1:0]             axis_out_tkeep,
   output logic                                 axis_out_tlast,
   output logic                                 axis_out_tvalid,
   input  logic                                 axis_out_tready,
   input  logic [NUM_AXIS_ID-1:0]               route_mask_in,
   input  logic                                 parsing_done_in,
   input  logic [PACKET_LENGTH_CBITS-1:0]       cur_pos_in,
   input  logic [ADDED_CBITS-1:0]               added_offset_in,
   input  logic                                 next_has_ports,
   input  logic [NUM_AXIS_ID-1:0][15:0]         cam_lo,
   input  logic [NUM_AXIS_ID-1:0][15:0]         cam_hi,
   input  logic [NUM_AXIS_ID-1:0]               cam_range_en,
   input  logic [NUM_AXIS_ID-1:0]               cam_must_match,
   output logic [NUM_AXIS_ID-1:0]               route_mask_out,
   output logic                                 parsing_done_out,
   output logic                                 short_pkt
);

   localparam int LANE_BITS = $clog2(NUM_BUS_BYTES);
   localparam int PLC       = PACKET_LENGTH_CBITS;

   typedef enum logic [1:0] {S_WAIT, S_HALF, S_DONE} state_t;

   state_t                          state_q, state_d;
   logic [7:0]                      hold_q, hold_d;
   logic [NUM_AXIS_ID-1:0]          hit_q, hit_d;

   logic                            vb, lb, completing;
   logic [PLC-1:0]                  p_pos;
   logic [LANE_BITS-1:0]            p_lane, lane_nxt;
   logic                            straddle, beat_sel;
   logic [NUM_BUS_BYTES-1:0][7:0]   beat_bytes;
   logic [15:0]                     port_val;
   logic [NUM_AXIS_ID-1:0]          hit_live, mask_bit;
   logic                            unused_pos;

   // AXI-S passthrough
   assign axis_out_tdata  = axis_in_tdata;
   assign axis_out_tid    = axis_in_tid;
   assign axis_out_tdest  = axis_in_tdest;
   assign axis_out_tkeep  = axis_in_tkeep;
   assign axis_out_tlast  = axis_in_tlast;
   assign axis_out_tvalid = axis_in_tvalid;
   assign axis_in_tready  = axis_out_tready;

   assign vb = axis_in_tvalid & axis_out_tready;
   assign lb = vb & axis_in_tlast;

   // Field position; PLC bits hold PORT_OFFSET+MAX_ADDED_OFFSET without overflow
   assign p_pos      = PLC'(PORT_OFFSET) + PLC'(added_offset_in);
   assign p_lane     = p_pos[LANE_BITS-1:0];
   assign lane_nxt   = p_lane + LANE_BITS'(1);
   assign straddle   = (p_lane == LANE_BITS'(NUM_BUS_BYTES-1));
   assign beat_sel   = (p_pos[PLC-1:LANE_BITS] == cur_pos_in[PLC-1:LANE_BITS]);
   assign beat_bytes = axis_in_tdata;
   assign unused_pos = ^cur_pos_in[LANE_BITS-1:0];

   // In HALF the MSB byte came from the previous beat and the LSB byte is lane 0
   always_comb begin
      port_val = {beat_bytes[p_lane], beat_bytes[lane_nxt]};
      if (state_q == S_HALF) begin
         port_val = {hold_q, beat_bytes[0]};
      end
   end

   always_comb begin
      hit_live = '0;
      for (int k = 0; k < NUM_AXIS_ID; k++) begin
         if (cam_range_en[k]) begin
            hit_live[k] = (cam_lo[k] <= port_val) && (port_val <= cam_hi[k]);
         end else begin
            hit_live[k] = (port_val == cam_lo[k]);
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      hold_d     = hold_q;
      hit_d      = hit_q;
      completing = 1'b0;
      if (vb) begin
         case (state_q)
            S_WAIT: begin
               if (beat_sel) begin
                  if (!straddle) begin
                     completing = 1'b1;
                     state_d    = S_DONE;
                  end else begin
                     hold_d  = beat_bytes[p_lane];
                     state_d = S_HALF;
                  end
               end
            end
            S_HALF: begin
               completing = 1'b1;
               state_d    = S_DONE;
            end
            default: ;
         endcase
         if (completing) begin
            hit_d = hit_live;
         end
         // End of packet always rearms, even on the completing beat
         if (axis_in_tlast) begin
            state_d = S_WAIT;
            hold_d  = 8'h00;
         end
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= S_WAIT;
         hold_q  <= 8'h00;
         hit_q   <= '1;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         hit_q   <= hit_d;
      end
   end

   // Optimistic (all ones) until the port is known
   always_comb begin
      mask_bit = '1;
      if (completing) begin
         mask_bit = hit_live;
      end else if (state_q == S_DONE) begin
         mask_bit = hit_q;
      end
   end

   assign route_mask_out   = route_mask_in & (~cam_must_match | (next_has_ports ? mask_bit : '0));
   assign parsing_done_out = next_has_ports ? (completing | (state_q == S_DONE)) : parsing_done_in;
   assign short_pkt        = aresetn & lb & next_has_ports & (state_q != S_DONE) & ~completing;

endmodule
